pipe_stage_reg: RTL and testbench

//   Generic clocked pipeline-stage register that replaces the per-stage hand-written latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   It carries a control bundle and a data bundle with a valid/ready handshake, stall (hold) and flush (bubble insert).
//   An optional skid entry keeps ready_o registered so that no combinational ready path runs back through the pipeline.
//   The hazard unit drives stall_i and flush_i; the neighbouring stages drive the handshakes.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_entry.sv | 51 +++++
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 tb/tb_pipe_stage_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register.
//   PIPE_CTRL_W  : default width of the control bundle
//   PIPE_DATA_W  : default width of the data bundle
//   CTRL_BUBBLE  : control value presented downstream for an empty slot;
//                  all zeros, so RegWrite/MemWrite and friends stay inert
package pipe_pkg;

    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_DATA_W = 106;

    localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of a pipeline stage: valid flag, control bundle, data bundle.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset; clears valid, ctrl and data
//   clr_i   : drops the entry (valid falls); data is left untouched
//   load_i  : captures ctrl_i/data_i and marks the slot valid
//   ctrl_i  : control bundle to capture
//   data_i  : data bundle to capture
//   valid_o : slot holds an entry
//   ctrl_o  : stored control, forced to the bubble value while the slot is empty
//   data_o  : stored data, keeps its last value while the slot is empty
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;

    // stage register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
            data_p1 <= '0;
        end else if (clr_i) begin
            vld_p1  <= 1'b0;
        end else if (load_i) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= ctrl_i;
            data_p1 <= data_i;
        end
    end

    assign valid_o = vld_p1;
    assign ctrl_o  = vld_p1 ? ctrl_p1 : CTRL_W'(CTRL_BUBBLE);
    assign data_o  = data_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, stall and flush.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (beats flush and handshakes)
//   stall_i : output entry is not consumed this cycle
//   flush_i : kill held entries and any entry arriving this cycle
//   valid_i / ready_o / ctrl_i / data_i : upstream handshake and payload
//   valid_o / ready_i / ctrl_o / data_o : downstream handshake and payload
//   count_o : entries held (0..2, at most 1 when SKID=0)
// SKID=1 adds a second slot so ready_o comes straight from a flop; SKID=0
// uses one slot and a combinational ready_o.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic              accept;
    logic              drain;
    logic              main_vld;
    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic              skid_vld;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign accept = valid_i & ready_o;
    assign drain  = main_vld & ready_i & ~stall_i;

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic skid_clr;

            // A drain with the skid full refills main from skid; otherwise an
            // accept goes to main when main is free (or freeing), else to skid.
            // ready_o is low while skid is full, so the input never competes
            // with the skid-to-main move.
            assign main_load   = ~flush_i & ((drain & skid_vld) |
                                             (accept & (~main_vld | drain)));
            assign main_clr    = flush_i | (drain & ~main_load);
            assign main_ctrl_d = skid_vld ? skid_ctrl : ctrl_i;
            assign main_data_d = skid_vld ? skid_data : data_i;
            assign skid_load   = ~flush_i & accept & main_vld & ~drain;
            assign skid_clr    = flush_i | (drain & skid_vld);

            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clr_i   (skid_clr),
                .load_i  (skid_load),
                .ctrl_i  (ctrl_i),
                .data_i  (data_i),
                .valid_o (skid_vld),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );

            assign ready_o = ~skid_vld;
        end else begin : g_flat
            assign skid_vld    = 1'b0;
            assign skid_ctrl   = '0;
            assign skid_data   = '0;
            assign main_load   = ~flush_i & accept;
            assign main_clr    = flush_i | (drain & ~accept);
            assign main_ctrl_d = ctrl_i;
            assign main_data_d = data_i;
            assign ready_o     = ~main_vld | (ready_i & ~stall_i);
        end
    endgenerate

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (main_clr),
        .load_i  (main_load),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_vld),
        .ctrl_o  (ctrl_o),
        .data_o  (data_o)
    );

    assign valid_o = main_vld;
    // skid is only ever occupied while main is, so the sum is a 2-bit add
    assign count_o = {main_vld & skid_vld, main_vld ^ skid_vld};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 106;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic          valid_i = 1'b0, ready_i = 1'b0;
    logic [CW-1:0] ctrl_i = '0;
    logic [DW-1:0] data_i = '0;

    logic          s_ready, s_valid, f_ready, f_valid;
    logic [CW-1:0] s_ctrl, f_ctrl;
    logic [DW-1:0] s_data, f_data;
    logic [1:0]    s_count, f_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_skid (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(s_ready), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(s_valid), .ready_i(ready_i), .ctrl_o(s_ctrl), .data_o(s_data),
        .count_o(s_count));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_flat (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(f_ready), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(f_valid), .ready_i(ready_i), .ctrl_o(f_ctrl), .data_o(f_data),
        .count_o(f_count));

    // Reference model: each stage is a bounded FIFO of {ctrl,data}; the
    // visible data is whatever entry was last at the head.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last0 = '0;

    task automatic step();
        bit acc1, acc0, dr1, dr0;
        ent_t e;
        e    = '{c: ctrl_i, d: data_i};
        acc1 = valid_i && (q1.size() < 2);
        acc0 = valid_i && ((q0.size() == 0) || (ready_i && !stall_i));
        dr1  = (q1.size() > 0) && ready_i && !stall_i;
        dr0  = (q0.size() > 0) && ready_i && !stall_i;
        @(posedge clk);
        if (rst_i) begin
            q1.delete(); q0.delete();
            last1 = '0; last0 = '0;
        end else if (flush_i) begin
            q1.delete(); q0.delete();
        end else begin
            if (dr1) void'(q1.pop_front());
            if (acc1) q1.push_back(e);
            if (dr0) void'(q0.pop_front());
            if (acc0) q0.push_back(e);
        end
        if (q1.size() > 0) last1 = q1[0].d;
        if (q0.size() > 0) last0 = q0[0].d;
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        valid_i = v;
        ctrl_i  = c;
        data_i  = d;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; ready_i = 1'b1;
        drive(1'b1, 8'hFF, 106'h3);
        step(); step();
        rst_i = 1'b0;
        drive(1'b0, '0, '0);
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
        checks++; if (s_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", s_ctrl); end
        checks++; if (s_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", s_data); end
        checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", s_count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_flat_valid got=%b exp=0", f_valid); end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 8'(k + 8'h10), DW'(k));
            step();
            checks++; if (s_data !== DW'(k) || s_valid !== 1'b1) begin
                errors++; $display("FAIL stream_data k=%0d got=%0d/%b exp=%0d/1", k, s_data, s_valid, k);
            end
            checks++; if (s_ready !== 1'b1 || s_count !== 2'd1) begin
                errors++; $display("FAIL stream_ready k=%0d got=%b/%0d exp=1/1", k, s_ready, s_count);
            end
            checks++; if (f_data !== DW'(k) || f_valid !== 1'b1 || f_ctrl !== 8'(k + 8'h10)) begin
                errors++; $display("FAIL stream_flat k=%0d got=%0d/%b/%h", k, f_data, f_valid, f_ctrl);
            end
        end
        drive(1'b0, '0, '0);
        step();
        checks++; if (s_valid !== 1'b0 || s_ctrl !== 8'h00 || s_data !== DW'(4)) begin
            errors++; $display("FAIL stream_end got=%b/%h/%0d exp=0/00/4", s_valid, s_ctrl, s_data);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        drive(1'b1, 8'hA1, 106'hA); step();
        drive(1'b1, 8'hB2, 106'hB); step();
        drive(1'b0, '0, '0);
        checks++; if (s_count !== 2'd2 || s_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got count=%0d ready=%b exp=2/0", s_count, s_ready);
        end
        checks++; if (s_data !== 106'hA || s_ctrl !== 8'hA1) begin
            errors++; $display("FAIL bp_head got=%h/%h exp=a/a1", s_data, s_ctrl);
        end
        ready_i = 1'b1;
        step();
        checks++; if (s_data !== 106'hB || s_valid !== 1'b1 || s_count !== 2'd1 || s_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second got=%h/%b/%0d/%b exp=b/1/1/1", s_data, s_valid, s_count, s_ready);
        end
        step();
        checks++; if (s_valid !== 1'b0 || s_count !== 2'd0 || s_data !== 106'hB) begin
            errors++; $display("FAIL bp_empty got=%b/%0d/%h exp=0/0/b", s_valid, s_count, s_data);
        end
    endtask

    task automatic test_stall_flush();
        ready_i = 1'b1;
        drive(1'b1, 8'h5A, 106'h77); step();
        drive(1'b0, '0, '0);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (s_valid !== 1'b1 || s_ctrl !== 8'h5A || s_data !== 106'h77 || s_count !== 2'd1) begin
                errors++; $display("FAIL stall_hold k=%0d got=%b/%h/%h/%0d", k, s_valid, s_ctrl, s_data, s_count);
            end
        end
        // acceptance into the free slot continues during a stall
        drive(1'b1, 8'h66, 106'h88); step();
        checks++; if (s_count !== 2'd2 || s_data !== 106'h77 || s_ready !== 1'b0) begin
            errors++; $display("FAIL stall_accept got=%0d/%h/%b exp=2/77/0", s_count, s_data, s_ready);
        end
        stall_i = 1'b0; flush_i = 1'b1;
        drive(1'b1, 8'hFF, 106'h99); step();
        flush_i = 1'b0;
        drive(1'b0, '0, '0);
        checks++; if (s_valid !== 1'b0 || s_ctrl !== 8'h00 || s_count !== 2'd0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL flush got=%b/%h/%0d/%b exp=0/00/0/1", s_valid, s_ctrl, s_count, s_ready);
        end
        checks++; if (s_data !== 106'h77) begin errors++; $display("FAIL flush_data got=%h exp=77", s_data); end
        step();
        checks++; if (s_valid !== 1'b0 || f_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop got=%b/%b exp=0/0", s_valid, f_valid);
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        drive(1'b1, 8'h11, 106'h1); step();
        drive(1'b1, 8'h22, 106'h2); step();
        checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL rmid_fill got=%0d exp=2", s_count); end
        rst_i = 1'b1; flush_i = 1'b1;
        drive(1'b1, 8'h33, 106'h3); step();
        rst_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, '0, '0);
        checks++; if (s_valid !== 1'b0 || s_ctrl !== 8'h00 || s_data !== '0 || s_count !== 2'd0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_state got=%b/%h/%h/%0d/%b", s_valid, s_ctrl, s_data, s_count, s_ready);
        end
        ready_i = 1'b1; step();
        checks++; if (s_valid !== 1'b0 || f_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_retain got=%b/%b exp=0/0", s_valid, f_valid);
        end
    endtask

    task automatic test_flat();
        ready_i = 1'b0;
        drive(1'b1, 8'hC3, 106'hC); step();
        drive(1'b0, '0, '0);
        checks++; if (f_valid !== 1'b1 || f_ready !== 1'b0 || f_count !== 2'd1) begin
            errors++; $display("FAIL flat_hold got=%b/%b/%0d exp=1/0/1", f_valid, f_ready, f_count);
        end
        ready_i = 1'b1;
        drive(1'b1, 8'hD4, 106'hD);
        #1;
        checks++; if (f_ready !== 1'b1) begin errors++; $display("FAIL flat_comb_ready got=%b exp=1", f_ready); end
        step();
        checks++; if (f_valid !== 1'b1 || f_data !== 106'hD || f_ctrl !== 8'hD4) begin
            errors++; $display("FAIL flat_b2b1 got=%b/%h/%h exp=1/d/d4", f_valid, f_data, f_ctrl);
        end
        drive(1'b1, 8'hE5, 106'hE); step();
        checks++; if (f_valid !== 1'b1 || f_data !== 106'hE || f_count !== 2'd1) begin
            errors++; $display("FAIL flat_b2b2 got=%b/%h/%0d exp=1/e/1", f_valid, f_data, f_count);
        end
        drive(1'b0, '0, '0); step();
    endtask

    task automatic test_random();
        logic [CW-1:0] exp_c;
        for (int n = 0; n < 400; n++) begin
            rst_i   = ($urandom_range(63) == 0);
            flush_i = ($urandom_range(15) == 0);
            stall_i = ($urandom_range(7) == 0);
            ready_i = ($urandom_range(3) != 0);
            drive($urandom_range(1), 8'($urandom), {10'($urandom), $urandom, $urandom, $urandom});
            step();
            exp_c = (q1.size() > 0) ? q1[0].c : 8'h00;
            checks++; if (s_valid !== (q1.size() > 0) || s_ctrl !== exp_c || s_data !== last1 ||
                          s_count !== 2'(q1.size()) || s_ready !== (q1.size() < 2)) begin
                errors++; $display("FAIL rand_skid n=%0d got v=%b c=%h d=%h n=%0d r=%b exp v=%b c=%h d=%h n=%0d",
                                   n, s_valid, s_ctrl, s_data, s_count, s_ready, q1.size() > 0, exp_c, last1, q1.size());
            end
            exp_c = (q0.size() > 0) ? q0[0].c : 8'h00;
            checks++; if (f_valid !== (q0.size() > 0) || f_ctrl !== exp_c || f_data !== last0 ||
                          f_count !== 2'(q0.size()) ||
                          f_ready !== ((q0.size() == 0) || (ready_i && !stall_i))) begin
                errors++; $display("FAIL rand_flat n=%0d got v=%b c=%h d=%h n=%0d r=%b exp v=%b c=%h d=%h n=%0d",
                                   n, f_valid, f_ctrl, f_data, f_count, f_ready, q0.size() > 0, exp_c, last0, q0.size());
            end
        end
        rst_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall_flush();
        test_reset_mid();
        test_flat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
